// File: rtl/binary_mul_arbiter.sv
// binary_mul_arbiter: round-robin front end for one shared row-pipelined multiplier.
// Grants one requester at a time, holds its operands steady for LATENCY+1 cycles,
// captures the product and returns it on a tagged valid/ready response channel.
module binary_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 5,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_en,
  input  logic [2*WIDTH-1:0]       mul_p,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_p,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam int unsigned P_W   = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    r_id;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [P_W-1:0]     r_rsp_p;

  logic               w_found;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [WIDTH-1:0]   w_gnt_a;
  logic [WIDTH-1:0]   w_gnt_b;
  logic               w_grant;
  logic               w_capture;
  logic               w_rsp_hs;

  // Round-robin search: first valid requester starting just after the last winner.
  always_comb begin
    int unsigned v_idx;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    v_idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      v_idx = 32'(r_last) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_found && req_valid[ID_W'(v_idx)]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(v_idx);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    w_gnt_a = '0;
    w_gnt_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_gnt_a = req_a[i*WIDTH +: WIDTH];
        w_gnt_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) && w_found;
  assign w_capture = (r_state == S_HOLD) && (r_cnt == CNT_W'(LATENCY));
  assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found)   w_state_nxt = S_HOLD;
      S_HOLD:  if (w_capture) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: single-cycle grant strobe in IDLE, multiplier enable in HOLD.
  always_comb begin
    req_ready = '0;
    mul_en    = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (w_found && (w_gnt_idx == ID_W'(i))) req_ready[i] = 1'b1;
        end
      end
      S_HOLD: begin
        mul_en = 1'b1;
        busy   = 1'b1;
      end
      S_RESP: busy = 1'b1;
      default: ;
    endcase
  end

  // Operand hold, owner tracking and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_id    <= '0;
      r_last  <= ID_W'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else if (w_grant) begin
      r_mul_a <= w_gnt_a;
      r_mul_b <= w_gnt_b;
      r_id    <= w_gnt_idx;
      r_last  <= w_gnt_idx;
      r_cnt   <= '0;
    end else if (r_state == S_HOLD) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Response register: captured once the product has settled, released on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_p     <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id;
      r_rsp_p     <= mul_p;
    end else if (w_rsp_hs) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_p     = r_rsp_p;

endmodule

// File: tb/tb_binary_mul_arbiter.sv
// tb_binary_mul_arbiter: scoreboard bench with a behavioural pipelined multiplier.
module tb_binary_mul_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned LAT  = 5;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_en;
  logic [2*W-1:0]   mul_p;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [2*W-1:0]   rsp_p;
  logic             busy;

  binary_mul_arbiter #(.NUM_REQ(NREQ), .WIDTH(W), .LATENCY(LAT)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_en    (mul_en),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: product of the current operands appears LAT edges later.
  logic [2*W-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= (2*W)'(mul_a) * (2*W)'(mul_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[LAT-1];

  typedef struct packed {
    logic [1:0]     id;
    logic [2*W-1:0] p;
  } exp_t;

  exp_t           sb_q[$];
  int             gnt_id_q[$];
  int             gnt_cyc_q[$];
  logic [2*W-1:0] rsp_log[$];
  int             rsp_id_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rr_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard push on grant, pop on response; operand hold and timing checks.
  logic [W-1:0]   exp_a, exp_b;
  int             last_gcyc;
  logic           prev_rv, prev_hs;
  logic [2*W-1:0] prev_p;
  logic [1:0]     prev_id;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      prev_rv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      chk("rdy_onehot", 32'($onehot0(req_ready)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_a = req_a[i*W +: W];
          exp_b = req_b[i*W +: W];
          e.id  = 2'(i);
          e.p   = (2*W)'(exp_a) * (2*W)'(exp_b);
          sb_q.push_back(e);
          gnt_id_q.push_back(i);
          gnt_cyc_q.push_back(cyc);
          last_gcyc = cyc;
        end
      end
      if (mul_en) begin
        chk("mul_a_hold", 32'(mul_a), 32'(exp_a));
        chk("mul_b_hold", 32'(mul_b), 32'(exp_b));
      end
      if (rsp_valid && !prev_rv) chk("rsp_latency", 32'(cyc - last_gcyc), LAT + 2);
      if (prev_rv && !prev_hs) begin
        chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
        chk("rsp_p_stable", 32'(rsp_p), 32'(prev_p));
        chk("rsp_id_stable", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && rsp_ready) begin
        rsp_log.push_back(rsp_p);
        rsp_id_log.push_back(int'(rsp_id));
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_p", 32'(rsp_p), 32'(e.p));
        end
      end
      prev_rv = rsp_valid;
      prev_hs = rsp_valid && rsp_ready;
      prev_p  = rsp_p;
      prev_id = rsp_id;
    end
  end

  // Random response backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_valid[r]    = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && sb_q.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [W-1:0] held_a;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_state", 32'({req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_id, rsp_p, busy}), 32'd0);

    // Single request from requester 0
    rsp_ready = 1'b1;
    issue(0, 4'd13, 4'd11);
    @(negedge clk);
    chk("ready_pulse", 32'(req_ready), 32'd0);
    wait_rsp();
    chk("t1_p", 32'(rsp_p), 32'd143);
    chk("t1_id", 32'(rsp_id), 32'd0);
    wait_idle();

    // All four contending: order 0,1,2,3,0 at LAT+3 spacing
    do_reset();
    rsp_ready = 1'b1;
    gnt_id_q.delete();
    gnt_cyc_q.delete();
    rsp_log.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'(i + 2);
      req_b[i*W +: W] = W'(i + 3);
    end
    req_valid = '1;
    for (int n = 0; n < 200 && gnt_id_q.size() < 5; n++) @(posedge clk);
    #1 req_valid = '0;
    wait_idle();
    chk("t2_ngnt", 32'(gnt_id_q.size()), 32'd5);
    if (gnt_id_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("t2_order", 32'(gnt_id_q[k]), 32'(k % NREQ));
      for (int k = 1; k < 5; k++) chk("t2_interval", 32'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), LAT + 3);
    end
    if (rsp_log.size() >= 4) begin
      chk("t2_p0", 32'(rsp_log[0]), 32'd6);
      chk("t2_p1", 32'(rsp_log[1]), 32'd12);
      chk("t2_p2", 32'(rsp_log[2]), 32'd20);
      chk("t2_p3", 32'(rsp_log[3]), 32'd30);
    end else begin
      chk("t2_nrsp", 32'(rsp_log.size()), 32'd5);
    end

    // Backpressure in RESP; a short request pulse meanwhile must not be latched
    rsp_ready = 1'b0;
    issue(3, 4'd9, 4'd7);
    gnt_id_q.delete();
    wait_rsp();
    held_a = mul_a;
    for (int n = 0; n < 10; n++) begin
      if (n == 3) begin
        @(posedge clk);
        #1;
        req_a[1*W +: W] = 4'd2;
        req_b[1*W +: W] = 4'd2;
        req_valid[1]    = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
      end
      @(negedge clk);
      chk("t3_valid", 32'(rsp_valid), 32'd1);
      chk("t3_p", 32'(rsp_p), 32'd63);
      chk("t3_id", 32'(rsp_id), 32'd3);
      chk("t3_ready", 32'(req_ready), 32'd0);
      chk("t3_mul_a", 32'(mul_a), 32'(held_a));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    chk("t3_no_latch", 32'(gnt_id_q.size()), 32'd0);
    wait_idle();

    // Reset during HOLD at cnt=2; pending req2 wins afterwards, no stale response
    do_reset();
    rsp_ready = 1'b1;
    issue(1, 4'd5, 4'd6);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out", 32'({req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_id, rsp_p, busy}), 32'd0);
    req_a[2*W +: W] = 4'd14;
    req_b[2*W +: W] = 4'd3;
    req_valid[2]    = 1'b1;
    gnt_id_q.delete();
    rsp_log.delete();
    rsp_id_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 50 && gnt_id_q.size() == 0; n++) @(posedge clk);
    #1 req_valid[2] = 1'b0;
    chk("t5_ngnt", 32'(gnt_id_q.size()), 32'd1);
    if (gnt_id_q.size() > 0) chk("t5_gnt_id", 32'(gnt_id_q[0]), 32'd2);
    wait_idle();
    chk("t5_nrsp", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() > 0) begin
      chk("t5_p", 32'(rsp_log[0]), 32'd42);
      chk("t5_id", 32'(rsp_id_log[0]), 32'd2);
    end

    // Exhaustive operand sweep on random requesters with random backpressure
    rr_rand = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(int'($urandom_range(0, NREQ - 1)), W'(a), W'(b));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end
    wait_idle();
    rr_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
